// File: rtl/mem_arbiter_if.sv
// Bundle of the two cache miss/write-back ports and the shared memory port.
// The arbiter uses the slave view; the environment (caches + memory) uses master.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
);
  logic              I_mem_read;
  logic              I_mem_write;
  logic [ADDR_W-1:0] I_mem_addr;
  logic [DATA_W-1:0] I_mem_wdata;
  logic [DATA_W-1:0] I_mem_rdata;
  logic              I_mem_ready;

  logic              D_mem_read;
  logic              D_mem_write;
  logic [ADDR_W-1:0] D_mem_addr;
  logic [DATA_W-1:0] D_mem_wdata;
  logic [DATA_W-1:0] D_mem_rdata;
  logic              D_mem_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  I_mem_read, I_mem_write, I_mem_addr, I_mem_wdata,
    output I_mem_rdata, I_mem_ready,
    input  D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata,
    output D_mem_rdata, D_mem_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output I_mem_read, I_mem_write, I_mem_addr, I_mem_wdata,
    input  I_mem_rdata, I_mem_ready,
    output D_mem_read, D_mem_write, D_mem_addr, D_mem_wdata,
    input  D_mem_rdata, D_mem_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting the single memory port to the I-cache or D-cache,
// one block transaction at a time, with registered memory-side commands.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned DATA_W = 128
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StServeI = 2'd1,
    StServeD = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic i_req, d_req, pick_d;

  assign i_req  = bus.I_mem_read | bus.I_mem_write;
  assign d_req  = bus.D_mem_read | bus.D_mem_write;
  // On a tie the side that was not served last wins.
  assign pick_d = d_req & (~i_req | ~last_grant_q);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rd_d         = rd_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      StIdle: begin
        if (pick_d) begin
          state_d      = StServeD;
          last_grant_d = 1'b1;
          wr_d         = bus.D_mem_write;
          rd_d         = bus.D_mem_read & ~bus.D_mem_write;  // read+write resolves to write
          addr_d       = bus.D_mem_addr;
          wdata_d      = bus.D_mem_wdata;
        end else if (i_req) begin
          state_d      = StServeI;
          last_grant_d = 1'b0;
          wr_d         = bus.I_mem_write;
          rd_d         = bus.I_mem_read & ~bus.I_mem_write;
          addr_d       = bus.I_mem_addr;
          wdata_d      = bus.I_mem_wdata;
        end
      end
      StServeI, StServeD: begin
        if (bus.mem_ready) begin
          state_d = StIdle;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign bus.mem_read    = rd_q;
  assign bus.mem_write   = wr_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;

  assign bus.I_mem_ready = (state_q == StServeI) & bus.mem_ready;
  assign bus.D_mem_ready = (state_q == StServeD) & bus.mem_ready;
  assign bus.I_mem_rdata = bus.mem_rdata;
  assign bus.D_mem_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level reference model checked
// every cycle, plus literal expectations for latency, ordering and stability.
module tb_mem_arbiter;
  localparam int unsigned AW = 28;
  localparam int unsigned DW = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model: who owns the memory port (0 none, 1 I, 2 D) and what it asked for.
  int              m_owner = 0;
  int              m_last = 1;
  int              pick;
  logic            m_rd = 1'b0;
  logic            m_wr = 1'b0;
  logic [AW-1:0]   m_addr = '0;
  logic [DW-1:0]   m_wdata = '0;

  function automatic logic side_wr(input int s);
    return (s == 1) ? bus.I_mem_write : bus.D_mem_write;
  endfunction
  function automatic logic side_req(input int s);
    return (s == 1) ? (bus.I_mem_read | bus.I_mem_write) : (bus.D_mem_read | bus.D_mem_write);
  endfunction
  function automatic logic side_rd(input int s);
    return (s == 1) ? bus.I_mem_read : bus.D_mem_read;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_owner <= 0;
      m_last  <= 1;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end else if (m_owner == 0) begin
      pick = 0;
      if (side_req(1) && side_req(2)) pick = 3 - m_last;
      else if (side_req(2)) pick = 2;
      else if (side_req(1)) pick = 1;
      if (pick != 0) begin
        m_owner <= pick;
        m_last  <= pick;
        m_wr    <= side_wr(pick);
        m_rd    <= side_rd(pick) && !side_wr(pick);
        m_addr  <= (pick == 1) ? bus.I_mem_addr : bus.D_mem_addr;
        m_wdata <= (pick == 1) ? bus.I_mem_wdata : bus.D_mem_wdata;
      end
    end else if (bus.mem_ready) begin
      m_owner <= 0;
      m_rd    <= 1'b0;
      m_wr    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_mem_read", bus.mem_read, m_rd);
      chk("cyc_mem_write", bus.mem_write, m_wr);
      chk("cyc_mem_addr", bus.mem_addr, m_addr);
      chk("cyc_mem_wdata", bus.mem_wdata, m_wdata);
      chk("cyc_I_ready", bus.I_mem_ready, (m_owner == 1) && bus.mem_ready);
      chk("cyc_D_ready", bus.D_mem_ready, (m_owner == 2) && bus.mem_ready);
      chk("cyc_I_rdata", bus.I_mem_rdata, bus.mem_rdata);
      chk("cyc_D_rdata", bus.D_mem_rdata, bus.mem_rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stall(input int n);
    repeat (n) step();
  endtask

  // Step until a memory command appears; n is the number of edges taken.
  task automatic wait_cmd(input string tag, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20) begin
      step();
      n++;
      seen = bus.mem_read | bus.mem_write;
    end
    chk({tag, "_cmd_seen"}, seen, 1'b1);
  endtask

  task automatic finish_txn(input int side, input logic [DW-1:0] rdata, input string tag);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rdata;
    #1;
    chk({tag, "_rdy"}, (side == 1) ? bus.I_mem_ready : bus.D_mem_ready, 1'b1);
    chk({tag, "_other_rdy"}, (side == 1) ? bus.D_mem_ready : bus.I_mem_ready, 1'b0);
    chk({tag, "_rdata"}, (side == 1) ? bus.I_mem_rdata : bus.D_mem_rdata, rdata);
    step();
    bus.mem_ready = 1'b0;
    if (side == 1) begin
      bus.I_mem_read  = 1'b0;
      bus.I_mem_write = 1'b0;
    end else begin
      bus.D_mem_read  = 1'b0;
      bus.D_mem_write = 1'b0;
    end
    #1;
    chk({tag, "_idle_after"}, bus.mem_read | bus.mem_write, 1'b0);
  endtask

  initial begin
    int n;
    bus.I_mem_read  = 1'b0;
    bus.I_mem_write = 1'b0;
    bus.I_mem_addr  = '0;
    bus.I_mem_wdata = '0;
    bus.D_mem_read  = 1'b0;
    bus.D_mem_write = 1'b0;
    bus.D_mem_addr  = '0;
    bus.D_mem_wdata = '0;
    bus.mem_rdata   = '0;
    bus.mem_ready   = 1'b0;

    rst_n = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_mem_read", bus.mem_read, 1'b0);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_mem_wdata", bus.mem_wdata, '0);
    chk("rst_I_ready", bus.I_mem_ready, 1'b0);
    chk("rst_D_ready", bus.D_mem_ready, 1'b0);
    rst_n = 1'b1;

    // Lone D read
    bus.D_mem_read = 1'b1;
    bus.D_mem_addr = 28'h0000010;
    wait_cmd("t1", n);
    chk("t1_latency", n, 1);
    chk("t1_mem_read", bus.mem_read, 1'b1);
    chk("t1_mem_addr", bus.mem_addr, 28'h0000010);
    stall(4);
    finish_txn(2, 128'hDEADBEEF_00112233_44556677_8899AABB, "t1");

    // Tie after reset: D first, then I two cycles after D's ready
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    bus.I_mem_read = 1'b1;
    bus.I_mem_addr = 28'h0000100;
    bus.D_mem_read = 1'b1;
    bus.D_mem_addr = 28'h0000200;
    wait_cmd("t2a", n);
    chk("t2a_first_addr", bus.mem_addr, 28'h0000200);
    stall(2);
    finish_txn(2, 128'h1, "t2a_d");
    wait_cmd("t2a_i", n);
    chk("t2a_gap", n, 1);
    chk("t2a_second_addr", bus.mem_addr, 28'h0000100);
    finish_txn(1, 128'h2, "t2a_i");
    // D served last, so the next tie goes to I
    bus.D_mem_read = 1'b1;
    bus.D_mem_addr = 28'h0000300;
    wait_cmd("t2b", n);
    finish_txn(2, 128'h3, "t2b");
    bus.I_mem_read = 1'b1;
    bus.I_mem_addr = 28'h0000140;
    bus.D_mem_read = 1'b1;
    bus.D_mem_addr = 28'h0000240;
    wait_cmd("t2c", n);
    chk("t2c_first_addr", bus.mem_addr, 28'h0000140);
    finish_txn(1, 128'h4, "t2c_i");
    wait_cmd("t2c_d", n);
    chk("t2c_gap", n, 1);
    chk("t2c_second_addr", bus.mem_addr, 28'h0000240);
    finish_txn(2, 128'h5, "t2c_d");

    // D write held stable across a long stall, inputs disturbed mid-stall
    bus.D_mem_write = 1'b1;
    bus.D_mem_addr  = 28'h0000ABC;
    bus.D_mem_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    wait_cmd("t3", n);
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        bus.D_mem_addr  = 28'h0000FFF;
        bus.D_mem_wdata = 128'hFFFF;
      end
      chk("t3_write", bus.mem_write, 1'b1);
      chk("t3_read", bus.mem_read, 1'b0);
      chk("t3_addr", bus.mem_addr, 28'h0000ABC);
      chk("t3_wdata", bus.mem_wdata, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
      step();
    end
    finish_txn(2, 128'h6, "t3");

    // I request arrives while D is being served
    bus.D_mem_read = 1'b1;
    bus.D_mem_addr = 28'h0000400;
    wait_cmd("t4", n);
    step();
    bus.I_mem_read = 1'b1;
    bus.I_mem_addr = 28'h0000500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t4_I_ready_low", bus.I_mem_ready, 1'b0);
      chk("t4_addr_held", bus.mem_addr, 28'h0000400);
    end
    finish_txn(2, 128'h7, "t4_d");
    wait_cmd("t4_i", n);
    chk("t4_gap", n, 1);
    chk("t4_i_addr", bus.mem_addr, 28'h0000500);
    chk("t4_i_read", bus.mem_read, 1'b1);
    finish_txn(1, 128'h8, "t4_i");

    // Illegal read+write resolves to write
    bus.D_mem_read  = 1'b1;
    bus.D_mem_write = 1'b1;
    bus.D_mem_addr  = 28'h0000600;
    wait_cmd("t5", n);
    chk("t5_write", bus.mem_write, 1'b1);
    chk("t5_read", bus.mem_read, 1'b0);
    finish_txn(2, 128'h9, "t5");

    // Stray mem_ready while idle
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t6_I_ready", bus.I_mem_ready, 1'b0);
      chk("t6_D_ready", bus.D_mem_ready, 1'b0);
      chk("t6_cmd", bus.mem_read | bus.mem_write, 1'b0);
      step();
    end
    bus.mem_ready = 1'b0;

    // Reset during an I transaction, then a tie goes to D
    bus.I_mem_read = 1'b1;
    bus.I_mem_addr = 28'h0000700;
    wait_cmd("t7", n);
    stall(2);
    rst_n = 1'b0;
    step();
    bus.I_mem_read = 1'b0;
    #1;
    chk("t7_rst_read", bus.mem_read, 1'b0);
    chk("t7_rst_write", bus.mem_write, 1'b0);
    chk("t7_rst_addr", bus.mem_addr, '0);
    chk("t7_rst_wdata", bus.mem_wdata, '0);
    chk("t7_rst_I_ready", bus.I_mem_ready, 1'b0);
    rst_n = 1'b1;
    bus.I_mem_read = 1'b1;
    bus.I_mem_addr = 28'h0000710;
    bus.D_mem_read = 1'b1;
    bus.D_mem_addr = 28'h0000720;
    wait_cmd("t7b", n);
    chk("t7b_latency", n, 1);
    chk("t7b_first_addr", bus.mem_addr, 28'h0000720);
    finish_txn(2, 128'hA, "t7b_d");
    wait_cmd("t7b_i", n);
    chk("t7b_second_addr", bus.mem_addr, 28'h0000710);
    finish_txn(1, 128'hB, "t7b_i");

    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter sharing the single off-chip memory port between the instruction cache's and the data cache's miss/write-back interfaces. It accepts one block transaction at a time, selects between the two requesters with round-robin priority, and holds the granted address, data and command stable toward memory until memory signals `mem_ready`. It then steers the completion back to the requester that owns the transaction. It sits between the two cache controllers and the top-level memory pins.

## Interface
- `ADDR_W`, 28, block address width (word address >> 2).
- `DATA_W`, 128, block data width.
- `clk` in 1: single clock, all state updates on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `I_mem_read` in 1: I-cache block read request.
- `I_mem_write` in 1: I-cache block write request; unused by the current I-cache, tie 0.
- `I_mem_addr` in ADDR_W: I-cache block address.
- `I_mem_wdata` in DATA_W: I-cache write data.
- `I_mem_rdata` out DATA_W: read data to the I-cache.
- `I_mem_ready` out 1: completion pulse to the I-cache.
- `D_mem_read`, `D_mem_write`, `D_mem_addr`, `D_mem_wdata`, `D_mem_rdata`, `D_mem_ready`: same as the I-side signals, for the D-cache.
- `mem_read` out 1: read command to memory.
- `mem_write` out 1: write command to memory.
- `mem_addr` out ADDR_W: address to memory.
- `mem_wdata` out DATA_W: write data to memory.
- `mem_rdata` in DATA_W: read data from memory.
- `mem_ready` in 1: memory completion; high for one cycle per transaction.

## Operation
- FSM states:
  - IDLE: no grant, memory commands low.
  - SERVE_I: I-side request granted, memory transaction issued.
  - SERVE_D: D-side request granted, memory transaction issued.
- Register `last_grant` (1 bit, 0=I, 1=D) holds the side served most recently. Reset value is 0, so D wins the first tie.
- In IDLE, a side requests when its read or write input is high:
  - Only one side requests: grant that side.
  - Both request: grant the side not equal to `last_grant`.
  - Neither requests: stay in IDLE.
- On a grant edge, capture into registers the granted side's command (read/write), address and wdata, and update `last_grant`. The memory outputs are driven only from these registers, never combinationally from requester inputs.
- A requester asserting read and write together is illegal. The arbiter resolves it as a write: `mem_write`=1, `mem_read`=0.
- In SERVE_x with `mem_ready`=1:
  - `x_mem_ready`=1 in the same cycle (combinational).
  - FSM moves to IDLE at the next edge.
  - Captured command registers clear at the next edge.
- `x_mem_rdata` is `mem_rdata` passed through for both sides. It is qualified only by `x_mem_ready`.
- The non-granted side's `mem_ready` output is always 0.
- Requests arriving, or changing, while in SERVE_x are not sampled. They are evaluated in the next IDLE cycle.
- Requesters hold read, write, addr and wdata stable until they see their ready. They deassert at the edge where ready is seen.

## Timing
- Reset (`rst_n`=0 at an edge):
  - state=IDLE, `last_grant`=0.
  - `mem_read`=`mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
  - `I_mem_ready`=`D_mem_ready`=0.
- Reset mid-transaction abandons the transaction without signalling completion. Memory and caches are reset by the same `rst_n`.
- Grant latency: a request high in IDLE at cycle t gives the memory command high from cycle t+1.
- Completion: `mem_ready` in cycle k gives requester ready in cycle k; FSM is in IDLE at k+1. The earliest next memory command is at k+2, leaving one idle cycle between back-to-back transactions.
- Memory commands stay asserted continuously from grant until the cycle of `mem_ready`, inclusive.
- `mem_ready` seen while in IDLE is ignored. Neither ready output pulses.
- No timeout: the arbiter waits indefinitely for `mem_ready`.
- Round-robin fairness: with both sides requesting continuously, grants alternate D, I, D, I… Neither side waits for more than one foreign transaction.

## Test plan
- Reset, then D read at address 0x0000010 alone:
  - `mem_read`=1 and `mem_addr`=0x0000010 from the next cycle.
  - Memory returns 0xDEADBEEF_… with `mem_ready` after 5 cycles.
  - `D_mem_ready`=1 in that same cycle with that rdata; `I_mem_ready` stays 0.
  - FSM is in IDLE the cycle after.
- I and D both request in the same cycle after reset:
  - D is served first, then I starts 2 cycles after D's `mem_ready`.
  - Repeat the tie: I is served before D.
- D write with addr 0x0000ABC and wdata 0x1234…:
  - `mem_write`=1, `mem_read`=0, and addr and wdata held stable across a 10-cycle memory stall.
  - Change the D-side inputs mid-stall: the memory outputs do not change.
- I requests while D is in service:
  - `I_mem_ready` stays 0 during the D transaction.
  - I's `mem_read` rises exactly 2 cycles after D's `mem_ready`.
- D asserts read and write together: memory sees a write only.
- Stray `mem_ready` in IDLE: no ready pulse on either side.
- Reset asserted mid-SERVE_I: the next cycle has all outputs at 0 and FSM in IDLE; a subsequent D request is granted first.
